// File: rtl/mdio_phy_responder_if.sv
// MDIO pad and local CSR access signals of the Clause 22 PHY responder.
// slave: the responder side; master: the EMAC/CSR side driving it.
interface mdio_phy_responder_if;
    logic        mdc_i;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  reg_addr_o;
    logic        reg_rd_o;
    logic [15:0] reg_rdata_i;
    logic        reg_wr_o;
    logic [15:0] reg_wdata_o;
    logic        busy_o;
    logic        frame_err_o;

    modport slave (
        input  mdc_i, mdio_i, reg_rdata_i,
        output mdio_o, mdio_oe, reg_addr_o, reg_rd_o, reg_wr_o, reg_wdata_o,
        output busy_o, frame_err_o
    );

    modport master (
        output mdc_i, mdio_i, reg_rdata_i,
        input  mdio_o, mdio_oe, reg_addr_o, reg_rd_o, reg_wr_o, reg_wdata_o,
        input  busy_o, frame_err_o
    );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO responder for the soft SGMII PHY register block.
// MDC/MDIO are oversampled on the 100 MHz fabric clock; a frame addressed to
// PHY_ADDR becomes one single-cycle CSR read or write, and read data is
// shifted back onto the pad after the turnaround.
// Build macro MDIO_RESP_BCAST_EN: when defined, write frames to PHYAD 0 are
// also accepted as broadcast (reads to PHYAD 0 only if PHY_ADDR is 0).
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR    = 5'd1,
    parameter int         SYNC_STAGES = 2
) (
    input logic                 fpga_clk_100,
    input logic                 fpga_reset_n,
    mdio_phy_responder_if.slave bus
);
    localparam int         SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [5:0] PRE_FULL = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_OP      = 3'd2,
        S_PHYAD   = 3'd3,
        S_REGAD   = 3'd4,
        S_TA      = 3'd5,
        S_DATA_RD = 3'd6,
        S_DATA_WR = 3'd7
    } state_t;

    logic [SYNC_N-1:0] mdc_sync;
    logic [SYNC_N-1:0] mdio_sync;
    logic              mdc_prev;
    logic              vld_p0;
    logic              bit_p0;

    state_t            state;
    state_t            state_nxt;
    logic [5:0]        pre_cnt;
    logic [4:0]        bit_k;
    logic              op_hi;
    logic              is_rd;
    logic [15:0]       shreg;
    logic [4:0]        field5;
    logic              addr_hit;

    logic              oe_nxt;
    logic              o_nxt;
    logic              rd_nxt;
    logic              wr_nxt;
    logic              err_nxt;
    logic              busy_nxt;
    logic [4:0]        addr_nxt;
    logic [15:0]       wdata_nxt;

    // Last five received bits; holds PHYAD at bit 8 and REGAD at bit 13.
    assign field5 = {shreg[3:0], bit_p0};

`ifdef MDIO_RESP_BCAST_EN
    assign addr_hit = (field5 == PHY_ADDR) || (!is_rd && (field5 == 5'd0));
`else
    assign addr_hit = (field5 == PHY_ADDR);
`endif

    // Synchronize MDC/MDIO and register the MDC rising-edge strobe with its sampled bit.
    always_ff @(posedge fpga_clk_100 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            mdc_sync  <= '1;
            mdio_sync <= '1;
            mdc_prev  <= 1'b1;
            vld_p0    <= 1'b0;
            bit_p0    <= 1'b1;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_N-2:0], bus.mdc_i};
            mdio_sync <= {mdio_sync[SYNC_N-2:0], bus.mdio_i};
            mdc_prev  <= mdc_sync[SYNC_N-1];
            vld_p0    <= mdc_sync[SYNC_N-1] & ~mdc_prev;
            bit_p0    <= mdio_sync[SYNC_N-1];
        end
    end

    // Frame state register.
    always_ff @(posedge fpga_clk_100 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, advancing only on sampled MDC edges.
    always_comb begin
        state_nxt = state;
        if (vld_p0) begin
            unique case (state)
                S_IDLE:    if (!bit_p0 && (pre_cnt == PRE_FULL)) state_nxt = S_START;
                S_START:   state_nxt = bit_p0 ? S_OP : S_IDLE;
                S_OP:      if (bit_k == 5'd3) state_nxt = (op_hi != bit_p0) ? S_PHYAD : S_IDLE;
                S_PHYAD:   if (bit_k == 5'd8) state_nxt = addr_hit ? S_REGAD : S_IDLE;
                S_REGAD:   if (bit_k == 5'd13) state_nxt = S_TA;
                S_TA:      if (bit_k == 5'd15) state_nxt = is_rd ? S_DATA_RD : S_DATA_WR;
                S_DATA_RD: if (bit_k == 5'd31) state_nxt = S_IDLE;
                S_DATA_WR: if (bit_k == 5'd31) state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: next values for the pad, CSR strobes and status flags.
    always_comb begin
        oe_nxt    = bus.mdio_oe;
        o_nxt     = bus.mdio_o;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
        addr_nxt  = bus.reg_addr_o;
        wdata_nxt = bus.reg_wdata_o;
        busy_nxt  = (state_nxt != S_IDLE);
        if (vld_p0) begin
            unique case (state)
                S_START: err_nxt = ~bit_p0;
                S_REGAD: begin
                    if (bit_k == 5'd13) begin
                        addr_nxt = field5;
                        rd_nxt   = is_rd;
                    end
                end
                S_TA: begin
                    if (is_rd) begin
                        if (bit_k == 5'd14) begin
                            oe_nxt = 1'b1;
                            o_nxt  = 1'b0;
                        end else begin
                            o_nxt = shreg[15];
                        end
                    end
                end
                S_DATA_RD: begin
                    if (bit_k == 5'd31) begin
                        oe_nxt = 1'b0;
                        o_nxt  = 1'b1;
                    end else begin
                        o_nxt = shreg[15];
                    end
                end
                S_DATA_WR: begin
                    if (bit_k == 5'd31) begin
                        wdata_nxt = {shreg[14:0], bit_p0};
                        wr_nxt    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Preamble counter, bit index and opcode flags.
    always_ff @(posedge fpga_clk_100 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            pre_cnt <= 6'd0;
            bit_k   <= 5'd0;
            op_hi   <= 1'b0;
            is_rd   <= 1'b0;
        end else if (vld_p0) begin
            if (state == S_IDLE) begin
                bit_k <= 5'd1;
                if (!bit_p0) begin
                    pre_cnt <= 6'd0;
                end else if (pre_cnt != PRE_FULL) begin
                    pre_cnt <= pre_cnt + 6'd1;
                end
            end else begin
                pre_cnt <= 6'd0;
                bit_k   <= bit_k + 5'd1;
            end
            if ((state == S_OP) && (bit_k == 5'd2)) op_hi <= bit_p0;
            if ((state == S_OP) && (bit_k == 5'd3)) is_rd <= op_hi;
        end
    end

    // Shared shift register: collects address/write bits, or holds read data
    // from the first TA bit and presents its MSB to the pad.
    always_ff @(posedge fpga_clk_100) begin
        if (vld_p0) begin
            if ((state == S_TA) && (bit_k == 5'd14)) begin
                shreg <= bus.reg_rdata_i;
            end else begin
                shreg <= {shreg[14:0], bit_p0};
            end
        end
    end

    // Registered outputs; reset releases the pad immediately.
    always_ff @(posedge fpga_clk_100 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            bus.mdio_oe     <= 1'b0;
            bus.mdio_o      <= 1'b1;
            bus.reg_rd_o    <= 1'b0;
            bus.reg_wr_o    <= 1'b0;
            bus.reg_addr_o  <= 5'd0;
            bus.reg_wdata_o <= 16'd0;
            bus.busy_o      <= 1'b0;
            bus.frame_err_o <= 1'b0;
        end else begin
            bus.mdio_oe     <= oe_nxt;
            bus.mdio_o      <= o_nxt;
            bus.reg_rd_o    <= rd_nxt;
            bus.reg_wr_o    <= wr_nxt;
            bus.reg_addr_o  <= addr_nxt;
            bus.reg_wdata_o <= wdata_nxt;
            bus.busy_o      <= busy_nxt;
            bus.frame_err_o <= err_nxt;
        end
    end
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: an MDIO master model drives
// frames bit by bit, a monitor tallies strobes and pad activity, and a
// frame-level reference model decides what each frame must produce.
`timescale 1ns/1ps
module tb_mdio_phy_responder;
    localparam logic [4:0] PHY = 5'd1;
`ifdef MDIO_RESP_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_val = 1'b1;
    int   half = 20;
    int   n_checks = 0;
    int   n_fail = 0;

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          err_cnt = 0;
    int          oe_cnt = 0;
    int          both_cnt = 0;
    logic [4:0]  rd_addr = '0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;

    always #5 clk = ~clk;

    mdio_phy_responder_if bus();

    // Open-drain-like pad: responder wins when enabled, else master or pull-up.
    assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : m_val;

    mdio_phy_responder #(.PHY_ADDR(PHY), .SYNC_STAGES(2)) dut (
        .fpga_clk_100(clk),
        .fpga_reset_n(rst_n),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.reg_rd_o) begin
            rd_cnt++;
            rd_addr = bus.reg_addr_o;
        end
        if (bus.reg_wr_o) begin
            wr_cnt++;
            wr_addr = bus.reg_addr_o;
            wr_data = bus.reg_wdata_o;
        end
        if (bus.reg_rd_o && bus.reg_wr_o) both_cnt++;
        if (bus.frame_err_o) err_cnt++;
        if (bus.mdio_oe) oe_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One MDC period: master data changes with MDC low, pad sampled just before the rise.
    task automatic mdc_cycle(input logic b, input logic drive, output logic smp);
        m_val = drive ? b : 1'b1;
        repeat (half) @(negedge clk);
        smp = bus.mdio_i;
        bus.mdc_i = 1'b1;
        repeat (half) @(negedge clk);
        bus.mdc_i = 1'b0;
    endtask

    // Preamble plus 32 frame bits; the master releases the pad from TA on reads.
    task automatic run_frame(input int pre_n, input logic [1:0] st, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                             input int rst_k, output logic [15:0] rbits, output logic ta2,
                             output logic busy12);
        logic [31:0] fr;
        logic        s;
        logic        rd;
        rbits  = '0;
        ta2    = 1'b1;
        busy12 = 1'b0;
        rd     = (op == 2'b10);
        fr     = {st, op, phy, rg, 2'b10, wd};
        for (int i = 0; i < pre_n; i++) mdc_cycle(1'b1, 1'b1, s);
        for (int k = 0; k < 32; k++) begin
            mdc_cycle(fr[31-k], !(rd && (k >= 14)), s);
            if (k == 15) ta2 = s;
            if (k >= 16) rbits[31-k] = s;
            if (k == 12) busy12 = bus.busy_o;
            if (k == rst_k) begin
                check_val("oe_before_reset", 32'(bus.mdio_oe), 32'd1);
                rst_n = 1'b0;
                #1;
                check_val("oe_async_release", 32'(bus.mdio_oe), 32'd0);
                m_val = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
        end
        m_val = 1'b1;
    endtask

    // Reference model: outcome of a frame from the protocol rules alone,
    // assuming the responder was idle with a cleared preamble count.
    task automatic frame_check(input string tag, input int pre_n, input logic [1:0] st,
                               input logic [1:0] op, input logic [4:0] phy, input logic [4:0] rg,
                               input logic [15:0] wd, input logic [15:0] rdv);
        int          rd0, wr0, er0, oe0, bo0;
        logic [15:0] rb;
        logic        ta2, b12;
        logic        started, good, hit, acc, exp_rd, exp_wr, exp_err;
        bus.reg_rdata_i = rdv;
        rd0 = rd_cnt; wr0 = wr_cnt; er0 = err_cnt; oe0 = oe_cnt; bo0 = both_cnt;
        run_frame(pre_n, st, op, phy, rg, wd, -1, rb, ta2, b12);
        repeat (10) @(negedge clk);

        started = (pre_n >= 32);
        exp_err = started && (st == 2'b00);
        good    = started && (st == 2'b01) && ((op == 2'b10) || (op == 2'b01));
        hit     = (phy == PHY) || (BCAST && (op == 2'b01) && (phy == 5'd0));
        acc     = good && hit;
        exp_rd  = acc && (op == 2'b10);
        exp_wr  = acc && (op == 2'b01);

        check_val({tag, ".rd_pulses"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check_val({tag, ".wr_pulses"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        check_val({tag, ".err_pulses"}, 32'(err_cnt - er0), 32'(exp_err));
        check_val({tag, ".rd_wr_overlap"}, 32'(both_cnt - bo0), 32'd0);
        check_val({tag, ".oe_driven"}, 32'((oe_cnt - oe0) > 0), 32'(exp_rd));
        check_val({tag, ".busy_mid"}, 32'(b12), 32'(acc));
        check_val({tag, ".busy_end"}, 32'(bus.busy_o), 32'd0);
        check_val({tag, ".oe_end"}, 32'(bus.mdio_oe), 32'd0);
        if (exp_rd) begin
            check_val({tag, ".rd_addr"}, 32'(rd_addr), 32'(rg));
            check_val({tag, ".ta2"}, 32'(ta2), 32'd0);
            check_val({tag, ".rdata"}, 32'(rb), 32'(rdv));
        end
        if (exp_wr) begin
            check_val({tag, ".wr_addr"}, 32'(wr_addr), 32'(rg));
            check_val({tag, ".wr_data"}, 32'(wr_data), 32'(wd));
        end
    endtask

    initial begin
        logic [15:0] rb;
        logic        ta2, b12;
        int          rd0, wr0;
        logic [1:0]  st, op;
        logic [4:0]  phy;
        int          sel;

        bus.mdc_i       = 1'b0;
        bus.reg_rdata_i = 16'h0000;
        repeat (4) @(negedge clk);
        check_val("rst.mdio_oe", 32'(bus.mdio_oe), 32'd0);
        check_val("rst.mdio_o", 32'(bus.mdio_o), 32'd1);
        check_val("rst.reg_rd", 32'(bus.reg_rd_o), 32'd0);
        check_val("rst.reg_wr", 32'(bus.reg_wr_o), 32'd0);
        check_val("rst.reg_addr", 32'(bus.reg_addr_o), 32'd0);
        check_val("rst.reg_wdata", 32'(bus.reg_wdata_o), 32'd0);
        check_val("rst.busy", 32'(bus.busy_o), 32'd0);
        check_val("rst.frame_err", 32'(bus.frame_err_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        half = 20;
        frame_check("wr_reg4", 32, 2'b01, 2'b01, PHY, 5'h04, 16'h01E1, 16'h0000);
        frame_check("rd_reg2", 32, 2'b01, 2'b10, PHY, 5'h02, 16'h0000, 16'h0141);
        frame_check("rd_phy3", 32, 2'b01, 2'b10, 5'd3, 5'h02, 16'h0000, 16'hBEEF);
        frame_check("wr_clean", 32, 2'b01, 2'b01, PHY, 5'h10, 16'h8001, 16'h0000);
        frame_check("pre31", 31, 2'b01, 2'b01, PHY, 5'h05, 16'h1234, 16'h0000);
        frame_check("st00", 32, 2'b00, 2'b10, PHY, 5'h03, 16'h0000, 16'h5555);
        frame_check("op00", 33, 2'b01, 2'b00, PHY, 5'h03, 16'hFFFF, 16'h0000);
        frame_check("op11", 32, 2'b01, 2'b11, PHY, 5'h03, 16'hFFFF, 16'h0000);

        half = 10;
        bus.reg_rdata_i = 16'hA5C3;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run_frame(32, 2'b01, 2'b10, PHY, 5'h07, 16'h0000, 20, rb, ta2, b12);
        check_val("rst_mid.rd_pulses", 32'(rd_cnt - rd0), 32'd1);
        check_val("rst_mid.wr_pulses", 32'(wr_cnt - wr0), 32'd0);
        check_val("rst_mid.busy", 32'(bus.busy_o), 32'd0);
        frame_check("after_rst", 32, 2'b01, 2'b10, PHY, 5'h07, 16'h0000, 16'h3C5A);

        frame_check("bcast_wr", 32, 2'b01, 2'b01, 5'd0, 5'h00, 16'h9140, 16'h0000);
        frame_check("bcast_rd", 32, 2'b01, 2'b10, 5'd0, 5'h01, 16'h0000, 16'h796D);

        for (int n = 0; n < 16; n++) begin
            half = $urandom_range(5, 12);
            sel  = $urandom_range(0, 3);
            phy  = (sel == 0) ? 5'd0 : ((sel == 3) ? 5'($urandom_range(0, 31)) : PHY);
            op   = 2'($urandom_range(0, 3));
            st   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
            frame_check($sformatf("rand%0d", n), 32 + $urandom_range(0, 3), st, op, phy,
                        5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
